// File: rtl/push_down_stack_ctrl_pkg.sv
// Shared definitions for the push-down stack controller: default sizes and FSM state encoding.
package push_down_stack_ctrl_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2,
        StResp  = 2'd3
    } state_e;

endpackage

// File: rtl/stack_ptr_counter.sv
// Up/down counter with enable and asynchronous active-low clear; holds the stack entry count.
module stack_ptr_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = up_i ? cnt_q + Width'(1) : cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/push_down_stack_ctrl.sv
// Push-down stack controller in front of a single-port RAM with one-cycle read latency.
// Defining STACK_PEEK_EN adds a Peek input that reads the top entry without popping it.
module push_down_stack_ctrl
    import push_down_stack_ctrl_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DefDataWidth,
    parameter int unsigned ADDRWIDTH = DefAddrWidth
) (
    input  logic                 Clk,
    input  logic                 ClrN,
    input  logic                 Push,
    input  logic                 Pop,
`ifdef STACK_PEEK_EN
    input  logic                 Peek,
`endif
    input  logic [DATAWIDTH-1:0] DataIn,
    output logic                 Ready,
    output logic                 Valid,
    output logic [DATAWIDTH-1:0] DataOut,
    output logic                 Full,
    output logic                 Empty,
    output logic                 Err,
    output logic [ADDRWIDTH-1:0] RamAddr,
    output logic                 RamWe,
    output logic [DATAWIDTH-1:0] RamDin,
    input  logic [DATAWIDTH-1:0] RamDout
);

    localparam logic [ADDRWIDTH:0] DepthVal = {1'b1, {ADDRWIDTH{1'b0}}};

    state_e               state_d, state_q;
    logic [DATAWIDTH-1:0] wdata_d, wdata_q;
    logic [DATAWIDTH-1:0] dout_d, dout_q;
    logic                 valid_d, valid_q;
    logic                 err_d, err_q;
    logic                 sp_en, sp_up;
    logic [ADDRWIDTH:0]   sp;
    logic [ADDRWIDTH-1:0] top_addr;
    logic                 cmd_conflict;
`ifdef STACK_PEEK_EN
    logic                 peek_d, peek_q;
`endif

    stack_ptr_counter #(
        .Width(ADDRWIDTH + 1)
    ) u_sp (
        .clk_i (Clk),
        .rst_ni(ClrN),
        .en_i  (sp_en),
        .up_i  (sp_up),
        .cnt_o (sp)
    );

    assign Empty = (sp == '0);
    assign Full  = (sp == DepthVal);
    // Wraps correctly when full: the low bits are zero, so minus one gives DEPTH-1.
    assign top_addr = sp[ADDRWIDTH-1:0] - ADDRWIDTH'(1);

`ifdef STACK_PEEK_EN
    assign cmd_conflict = (Push && Pop) || (Peek && (Push || Pop));
`else
    assign cmd_conflict = Push && Pop;
`endif

    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        sp_en   = 1'b0;
        sp_up   = 1'b0;
        Ready   = 1'b0;
        RamWe   = 1'b0;
        RamAddr = '0;
        RamDin  = '0;
`ifdef STACK_PEEK_EN
        peek_d  = peek_q;
`endif
        unique case (state_q)
            StIdle: begin
                Ready = 1'b1;
                if (cmd_conflict) begin
                    err_d = 1'b1;
                end else if (Push) begin
                    if (Full) begin
                        err_d = 1'b1;
                    end else begin
                        wdata_d = DataIn;
                        state_d = StWrite;
                    end
                end else if (Pop) begin
                    if (Empty) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StRead;
`ifdef STACK_PEEK_EN
                        peek_d  = 1'b0;
`endif
                    end
`ifdef STACK_PEEK_EN
                end else if (Peek) begin
                    if (Empty) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StRead;
                        peek_d  = 1'b1;
                    end
`endif
                end
            end
            StWrite: begin
                RamWe   = 1'b1;
                RamAddr = sp[ADDRWIDTH-1:0];
                RamDin  = wdata_q;
                sp_en   = 1'b1;
                sp_up   = 1'b1;
                state_d = StIdle;
            end
            StRead: begin
                RamAddr = top_addr;
`ifdef STACK_PEEK_EN
                sp_en   = !peek_q;
`else
                sp_en   = 1'b1;
`endif
                state_d = StResp;
            end
            StResp: begin
                dout_d  = RamDout;
                valid_d = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state_q <= StIdle;
            wdata_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef STACK_PEEK_EN
            peek_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef STACK_PEEK_EN
            peek_q  <= peek_d;
`endif
        end
    end

    assign Valid   = valid_q;
    assign Err     = err_q;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_push_down_stack_ctrl.sv
// Scoreboard bench for push_down_stack_ctrl with a 4-entry behavioural RAM.
module tb_push_down_stack_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    logic          Clk = 1'b0;
    logic          ClrN;
    logic          Push, Pop;
`ifdef STACK_PEEK_EN
    logic          Peek;
`endif
    logic [DW-1:0] DataIn;
    logic          Ready, Valid, Full, Empty, Err, RamWe;
    logic [DW-1:0] DataOut, RamDin, RamDout;
    logic [AW-1:0] RamAddr;

    logic [DW-1:0] mem [4];

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            pop_cyc = 0;
    int            n_valid_exp  = 0;
    int            n_valid_seen = 0;
    logic [DW-1:0] model [$];
    logic [AW+DW-1:0] wr_q [$];
    logic [DW-1:0] rd_q [$];
    logic [AW+DW-1:0] wr_exp;

    push_down_stack_ctrl #(
        .DATAWIDTH(DW),
        .ADDRWIDTH(AW)
    ) dut (
        .Clk    (Clk),
        .ClrN   (ClrN),
        .Push   (Push),
        .Pop    (Pop),
`ifdef STACK_PEEK_EN
        .Peek   (Peek),
`endif
        .DataIn (DataIn),
        .Ready  (Ready),
        .Valid  (Valid),
        .DataOut(DataOut),
        .Full   (Full),
        .Empty  (Empty),
        .Err    (Err),
        .RamAddr(RamAddr),
        .RamWe  (RamWe),
        .RamDin (RamDin),
        .RamDout(RamDout)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (RamWe) mem[RamAddr] <= RamDin;
        RamDout <= mem[RamAddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: RAM writes and popped words are compared against the scoreboard queues.
    always @(negedge Clk) begin
        if (ClrN) begin
            if (RamWe) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_exp = wr_q.pop_front();
                    check("wr_addr", 32'(RamAddr), 32'(wr_exp[AW+DW-1:DW]));
                    check("wr_data", 32'(RamDin), 32'(wr_exp[DW-1:0]));
                end
            end
            if (Valid) begin
                n_valid_seen++;
                check("valid_latency", cyc - pop_cyc, 3);
                if (rd_q.size() == 0) check("unexpected_valid", 1, 0);
                else check("dout", 32'(DataOut), 32'(rd_q.pop_front()));
            end
        end
    end

    task automatic do_push(input logic [DW-1:0] d);
        logic exp_err;
        check("push_ready", 32'(Ready), 1);
        exp_err = (model.size() == 4);
        if (!exp_err) begin
            wr_q.push_back({AW'(model.size()), d});
            model.push_back(d);
        end
        Push = 1'b1;
        DataIn = d;
        @(negedge Clk);
        Push = 1'b0;
        check("push_err", 32'(Err), 32'(exp_err));
        if (exp_err) check("push_err_no_we", 32'(RamWe), 0);
        @(negedge Clk);
        check("push_err_pulse", 32'(Err), 0);
        check("push_ready_after", 32'(Ready), 1);
        check("push_full", 32'(Full), 32'(model.size() == 4));
        check("push_empty", 32'(Empty), 32'(model.size() == 0));
    endtask

    task automatic do_pop();
        logic exp_err;
        check("pop_ready", 32'(Ready), 1);
        exp_err = (model.size() == 0);
        if (!exp_err) begin
            rd_q.push_back(model[$]);
            void'(model.pop_back());
            n_valid_exp++;
        end
        Pop = 1'b1;
        pop_cyc = cyc;
        @(negedge Clk);
        Pop = 1'b0;
        check("pop_err", 32'(Err), 32'(exp_err));
        check("pop_no_we", 32'(RamWe), 0);
        repeat (3) @(negedge Clk);
        check("pop_full", 32'(Full), 32'(model.size() == 4));
        check("pop_empty", 32'(Empty), 32'(model.size() == 0));
    endtask

`ifdef STACK_PEEK_EN
    task automatic do_peek();
        logic exp_err;
        exp_err = (model.size() == 0);
        if (!exp_err) begin
            rd_q.push_back(model[$]);
            n_valid_exp++;
        end
        Peek = 1'b1;
        pop_cyc = cyc;
        @(negedge Clk);
        Peek = 1'b0;
        check("peek_err", 32'(Err), 32'(exp_err));
        repeat (3) @(negedge Clk);
        check("peek_empty", 32'(Empty), 32'(model.size() == 0));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ClrN = 1'b0;
        Push = 1'b0;
        Pop = 1'b0;
        DataIn = '0;
`ifdef STACK_PEEK_EN
        Peek = 1'b0;
`endif
        repeat (2) @(negedge Clk);
        ClrN = 1'b1;
        @(negedge Clk);
        check("rst_empty", 32'(Empty), 1);
        check("rst_full", 32'(Full), 0);
        check("rst_ready", 32'(Ready), 1);
        check("rst_valid", 32'(Valid), 0);
        check("rst_dout", 32'(DataOut), 0);
        check("rst_err", 32'(Err), 0);
        check("rst_we", 32'(RamWe), 0);

        // Fill, overflow, drain, underflow.
        do_push(8'h11);
        do_push(8'h22);
        do_push(8'h33);
        do_push(8'h44);
        do_push(8'h55);
        repeat (5) do_pop();

        // Simultaneous push and pop with two entries stored.
        do_push(8'hAA);
        do_push(8'hBB);
        Push = 1'b1;
        Pop = 1'b1;
        DataIn = 8'hCC;
        @(negedge Clk);
        Push = 1'b0;
        Pop = 1'b0;
        check("pp_err", 32'(Err), 1);
        check("pp_no_we", 32'(RamWe), 0);
        check("pp_ready", 32'(Ready), 1);
        @(negedge Clk);
        check("pp_err_pulse", 32'(Err), 0);
        do_pop();
        do_pop();

        // Reset in the middle of a pop with three entries stored.
        do_push(8'h01);
        do_push(8'h02);
        do_push(8'h03);
        Pop = 1'b1;
        pop_cyc = cyc;
        @(negedge Clk);
        Pop = 1'b0;
        check("rd_ready_low", 32'(Ready), 0);
        #2 ClrN = 1'b0;
        #1;
        check("abort_ready", 32'(Ready), 1);
        check("abort_empty", 32'(Empty), 1);
        check("abort_full", 32'(Full), 0);
        check("abort_valid", 32'(Valid), 0);
        check("abort_dout", 32'(DataOut), 0);
        check("abort_we", 32'(RamWe), 0);
        model.delete();
        rd_q.delete();
        @(negedge Clk);
        ClrN = 1'b1;
        repeat (4) @(negedge Clk);
        check("abort_no_valid_yet", 32'(n_valid_seen), 32'(n_valid_exp));
        do_push(8'h5A);
        do_pop();

`ifdef STACK_PEEK_EN
        do_push(8'hA5);
        do_peek();
        do_peek();
        check("peek_not_full", 32'(Full), 0);
        do_pop();
        check("peek_final_empty", 32'(Empty), 1);
`endif

        repeat (4) @(negedge Clk);
        check("valid_count", 32'(n_valid_seen), 32'(n_valid_exp));
        check("wr_q_drained", 32'(wr_q.size()), 0);
        check("rd_q_drained", 32'(rd_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
